// File: rtl/bf16_dot_feeder_44_if.sv
// Handshake and MAC-side signal bundle for the BF16 dot-product feeder.
// slave is the feeder's view; master is the view of whatever drives it.
interface bf16_dot_feeder_44_if #(
    parameter int NUM_ELEM = 12,
    parameter int ELEM_W   = 16
);
    logic                         in_valid_44;
    logic                         in_ready_44;
    logic [ELEM_W-1:0]            in_a_44;
    logic [ELEM_W-1:0]            in_b_44;
    logic                         mac_start_44;
    logic [NUM_ELEM*ELEM_W-1:0]   mac_vector_a_flat_44;
    logic [NUM_ELEM*ELEM_W-1:0]   mac_vector_b_flat_44;
    logic                         mac_done_44;
    logic [ELEM_W-1:0]            mac_result_44;
    logic                         out_valid_44;
    logic                         out_ready_44;
    logic [ELEM_W-1:0]            out_result_44;
    logic                         busy_44;
    logic                         timeout_err_44;

    modport slave (
        input  in_valid_44, in_a_44, in_b_44, mac_done_44, mac_result_44, out_ready_44,
        output in_ready_44, mac_start_44, mac_vector_a_flat_44, mac_vector_b_flat_44,
               out_valid_44, out_result_44, busy_44, timeout_err_44
    );

    modport master (
        output in_valid_44, in_a_44, in_b_44, mac_done_44, mac_result_44, out_ready_44,
        input  in_ready_44, mac_start_44, mac_vector_a_flat_44, mac_vector_b_flat_44,
               out_valid_44, out_result_44, busy_44, timeout_err_44
    );
endinterface

// File: rtl/bf16_dot_feeder_44.sv
// Packs A/B element pairs for BF16DotProduct_44, starts it, waits for done
// (with a timeout guard) and hands the result downstream.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_LOAD   | accepting element pairs into slots 0..NUM_ELEM-1
// S_START  | one-cycle mac_start pulse; clears timer and timeout flag
// S_WAIT   | waiting for a rising edge of mac_done or timer expiry
// S_OUTPUT | result presented on out_valid until downstream accepts it
module bf16_dot_feeder_44 #(
    parameter int          NUM_ELEM       = 12,
    parameter int          ELEM_W         = 16,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [15:0] NAN_VALUE      = 16'h7FC0
) (
    input  logic                  clk_44,
    input  logic                  rst_n_44,
    bf16_dot_feeder_44_if.slave   io_bus
);
    localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ELEM - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT, S_OUTPUT} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [IDX_W-1:0]           r_idx;
    logic [TMR_W-1:0]           r_timer;
    logic [NUM_ELEM*ELEM_W-1:0] r_flat_a;
    logic [NUM_ELEM*ELEM_W-1:0] r_flat_b;
    logic [ELEM_W-1:0]          r_out_result;
    logic                       r_timeout_err;
    logic                       r_done_q;

    logic w_accept;
    logic w_done_edge;
    logic w_timeout;
    logic w_in_ready;
    logic w_mac_start;
    logic w_out_valid;
    logic w_busy;

    // A done level held over from the previous job must not count as completion.
    assign w_done_edge = io_bus.mac_done_44 & ~r_done_q;
    assign w_timeout   = (r_timer == TMR_LAST);
    assign w_accept    = w_in_ready & io_bus.in_valid_44;

    always_ff @(posedge clk_44 or negedge rst_n_44) begin
        if (!rst_n_44) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_mac_start = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_LOAD: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                if (io_bus.in_valid_44 && (r_idx == IDX_LAST)) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_mac_start = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_done_edge || w_timeout) begin
                    w_state_nxt = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                w_out_valid = 1'b1;
                if (io_bus.out_ready_44) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk_44 or negedge rst_n_44) begin
        if (!rst_n_44) begin
            r_idx         <= '0;
            r_timer       <= '0;
            r_flat_a      <= '0;
            r_flat_b      <= '0;
            r_out_result  <= '0;
            r_timeout_err <= 1'b0;
            r_done_q      <= 1'b0;
        end else begin
            r_done_q <= io_bus.mac_done_44;
            case (r_state)
                S_LOAD: begin
                    if (w_accept) begin
                        for (int i = 0; i < NUM_ELEM; i++) begin
                            if (r_idx == IDX_W'(i)) begin
                                r_flat_a[i*ELEM_W +: ELEM_W] <= io_bus.in_a_44;
                                r_flat_b[i*ELEM_W +: ELEM_W] <= io_bus.in_b_44;
                            end
                        end
                        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                    end
                end
                S_START: begin
                    r_timer       <= '0;
                    r_timeout_err <= 1'b0;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    // Completion takes priority over a simultaneous timeout.
                    if (w_done_edge) begin
                        r_out_result <= io_bus.mac_result_44;
                    end else if (w_timeout) begin
                        r_out_result  <= ELEM_W'(NAN_VALUE);
                        r_timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.in_ready_44          = w_in_ready;
    assign io_bus.mac_start_44         = w_mac_start;
    assign io_bus.mac_vector_a_flat_44 = r_flat_a;
    assign io_bus.mac_vector_b_flat_44 = r_flat_b;
    assign io_bus.out_valid_44         = w_out_valid;
    assign io_bus.out_result_44        = r_out_result;
    assign io_bus.busy_44              = w_busy;
    assign io_bus.timeout_err_44       = r_timeout_err;
endmodule

// File: tb/tb_bf16_dot_feeder_44.sv
// Directed bench for bf16_dot_feeder_44: a job-level timestamp model checked
// every cycle, plus literal expectations for the nominal and corner cases.
module tb_bf16_dot_feeder_44;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bf16_dot_feeder_44_if bus ();

    bf16_dot_feeder_44 dut (
        .clk_44   (clk),
        .rst_n_44 (rst_n),
        .io_bus   (bus)
    );

    int total = 0;
    int bad = 0;
    int tcyc = 0;
    int n_starts = 0;

    logic [15:0] NOM_A [12] = '{16'h3dcc, 16'h3e4c, 16'h3e80, 16'hbe99, 16'h3ecc, 16'h3f00,
                                16'h3f0c, 16'h3f19, 16'hbf40, 16'h3f4c, 16'h3f60, 16'h3f66};
    logic [15:0] NOM_B [12] = '{16'h3e80, 16'hbf66, 16'h3e00, 16'h3f4c, 16'h3f60, 16'hbf40,
                                16'h3e99, 16'h3f19, 16'h3dcc, 16'h3e4c, 16'hbecc, 16'h3f0c};
    logic [15:0] cur_a [12];
    logic [15:0] cur_b [12];

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Job-level reference: pairs land in slots, start follows the last accept
    // by one cycle, the result appears the cycle after a done edge seen after
    // start, or 64 waiting cycles after start without one.
    logic [15:0] m_slot_a [12];
    logic [15:0] m_slot_b [12];
    int          m_cnt = 0;
    int          m_cyc = 0;
    int          m_start_cyc = -1;
    bit          m_load_open = 1'b1;
    bit          m_out = 1'b0;
    bit          m_terr = 1'b0;
    bit          m_dprev = 1'b0;
    logic [15:0] m_res = 16'h0;

    initial for (int i = 0; i < 12; i++) begin
        m_slot_a[i] = 16'h0;
        m_slot_b[i] = 16'h0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 12; i++) begin
                m_slot_a[i] = 16'h0;
                m_slot_b[i] = 16'h0;
            end
            m_cnt = 0; m_start_cyc = -1; m_load_open = 1'b1; m_out = 1'b0;
            m_terr = 1'b0; m_dprev = 1'b0; m_res = 16'h0;
        end else begin
            if (m_load_open) begin
                if (bus.in_valid_44) begin
                    m_slot_a[m_cnt] = bus.in_a_44;
                    m_slot_b[m_cnt] = bus.in_b_44;
                    m_cnt++;
                    if (m_cnt == 12) begin
                        m_cnt = 0;
                        m_load_open = 1'b0;
                        m_start_cyc = m_cyc + 1;
                    end
                end
            end else if (m_out) begin
                if (bus.out_ready_44) begin
                    m_out = 1'b0;
                    m_load_open = 1'b1;
                end
            end else if (m_cyc > m_start_cyc) begin
                if (bus.mac_done_44 && !m_dprev) begin
                    m_res = bus.mac_result_44;
                    m_out = 1'b1;
                end else if (m_cyc == m_start_cyc + 64) begin
                    m_res = 16'h7fc0;
                    m_terr = 1'b1;
                    m_out = 1'b1;
                end
            end
            if (m_cyc == m_start_cyc) m_terr = 1'b0;
            m_dprev = bus.mac_done_44;
            m_cyc++;
        end
    end

    always @(posedge clk) tcyc++;

    always @(negedge clk) begin
        logic [191:0] ea, eb;
        for (int i = 0; i < 12; i++) begin
            ea[i*16 +: 16] = m_slot_a[i];
            eb[i*16 +: 16] = m_slot_b[i];
        end
        if (bus.mac_start_44 === 1'b1) n_starts++;
        chk("in_ready", 192'(bus.in_ready_44), 192'(m_load_open));
        chk("busy", 192'(bus.busy_44), 192'(!m_load_open));
        chk("mac_start", 192'(bus.mac_start_44), 192'(!m_load_open && (m_cyc == m_start_cyc)));
        chk("out_valid", 192'(bus.out_valid_44), 192'(m_out));
        chk("out_result", 192'(bus.out_result_44), 192'(m_res));
        chk("timeout_err", 192'(bus.timeout_err_44), 192'(m_terr));
        chk("flat_a", bus.mac_vector_a_flat_44, ea);
        chk("flat_b", bus.mac_vector_b_flat_44, eb);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_job(input bit gaps);
        for (int i = 0; i < 12; i++) begin
            int guard;
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            guard = 0;
            while (bus.in_ready_44 !== 1'b1 && guard < 200) begin
                tick();
                guard++;
            end
            if (guard >= 200) chk("load_ready_bound", 192'(bus.in_ready_44), 192'(1));
            bus.in_valid_44 = 1'b1;
            bus.in_a_44 = cur_a[i];
            bus.in_b_44 = cur_b[i];
            tick();
            bus.in_valid_44 = 1'b0;
        end
        chk("start_after_last", 192'(bus.mac_start_44), 192'(1));
    endtask

    task automatic wait_out(input int lim, output int vcyc);
        int n = 0;
        while (bus.out_valid_44 !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
        if (bus.out_valid_44 !== 1'b1) chk("out_valid_bound", 192'(bus.out_valid_44), 192'(1));
        vcyc = tcyc;
    endtask

    task automatic mac_pulse(input int dly, input logic [15:0] res);
        repeat (dly) tick();
        bus.mac_done_44 = 1'b1;
        bus.mac_result_44 = res;
        tick();
        bus.mac_done_44 = 1'b0;
    endtask

    initial begin
        int s, v, n0;
        bus.in_valid_44 = 1'b0;
        bus.in_a_44 = '0;
        bus.in_b_44 = '0;
        bus.mac_done_44 = 1'b0;
        bus.mac_result_44 = '0;
        bus.out_ready_44 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cur_a[i] = NOM_A[i];
            cur_b[i] = NOM_B[i];
        end
        repeat (3) tick();
        chk("rst_in_ready", 192'(bus.in_ready_44), 192'(1));
        chk("rst_out_valid", 192'(bus.out_valid_44), 192'(0));
        chk("rst_flat_a", bus.mac_vector_a_flat_44, 192'(0));
        rst_n = 1'b1;
        tick();

        // nominal
        n0 = n_starts;
        send_job(1'b0);
        s = tcyc;
        mac_pulse(13, 16'h3eb8);
        wait_out(40, v);
        chk("nom_latency", 192'(v - s), 192'(14));
        chk("nom_result", 192'(bus.out_result_44), 192'(16'h3eb8));
        chk("nom_terr", 192'(bus.timeout_err_44), 192'(0));
        chk("nom_a0", 192'(bus.mac_vector_a_flat_44[15:0]), 192'(16'h3dcc));
        chk("nom_a11", 192'(bus.mac_vector_a_flat_44[191:176]), 192'(16'h3f66));
        chk("nom_b0", 192'(bus.mac_vector_b_flat_44[15:0]), 192'(16'h3e80));
        chk("nom_starts", 192'(n_starts - n0), 192'(1));
        tick();
        chk("nom_ready_back", 192'(bus.in_ready_44), 192'(1));

        // input gaps
        n0 = n_starts;
        send_job(1'b1);
        s = tcyc;
        mac_pulse(6, 16'h3eb8);
        wait_out(40, v);
        chk("gap_a11", 192'(bus.mac_vector_a_flat_44[191:176]), 192'(16'h3f66));
        chk("gap_b11", 192'(bus.mac_vector_b_flat_44[191:176]), 192'(16'h3f0c));
        chk("gap_starts", 192'(n_starts - n0), 192'(1));
        tick();

        // output backpressure
        bus.out_ready_44 = 1'b0;
        n0 = n_starts;
        send_job(1'b0);
        mac_pulse(13, 16'h3eb8);
        wait_out(40, v);
        for (int k = 0; k < 5; k++) begin
            chk("bp_hold_result", 192'(bus.out_result_44), 192'(16'h3eb8));
            chk("bp_in_ready", 192'(bus.in_ready_44), 192'(0));
            tick();
        end
        bus.out_ready_44 = 1'b1;
        chk("bp_still_valid", 192'(bus.out_valid_44), 192'(1));
        tick();
        chk("bp_ready_back", 192'(bus.in_ready_44), 192'(1));
        chk("bp_starts", 192'(n_starts - n0), 192'(1));

        // timeout
        send_job(1'b0);
        s = tcyc;
        wait_out(100, v);
        chk("to_latency", 192'(v - s), 192'(65));
        chk("to_result", 192'(bus.out_result_44), 192'(16'h7fc0));
        chk("to_terr", 192'(bus.timeout_err_44), 192'(1));
        tick();
        chk("to_terr_sticky", 192'(bus.timeout_err_44), 192'(1));

        // stale done, job 1: done rises and stays high
        send_job(1'b0);
        chk("st1_terr_in_start", 192'(bus.timeout_err_44), 192'(1));
        tick();
        chk("st1_terr_cleared", 192'(bus.timeout_err_44), 192'(0));
        repeat (11) tick();
        bus.mac_done_44 = 1'b1;
        bus.mac_result_44 = 16'h3e00;
        tick();
        wait_out(40, v);
        chk("st1_result", 192'(bus.out_result_44), 192'(16'h3e00));
        tick();

        // stale done, job 2: leftover level must be ignored
        for (int i = 0; i < 12; i++) begin
            cur_a[i] = 16'h4000 + 16'(i * 17);
            cur_b[i] = 16'hc000 + 16'(i);
        end
        send_job(1'b0);
        s = tcyc;
        repeat (2) tick();
        bus.mac_done_44 = 1'b0;
        mac_pulse(2, 16'h3f80);
        wait_out(40, v);
        chk("st2_result", 192'(bus.out_result_44), 192'(16'h3f80));
        chk("st2_latency", 192'(v - s), 192'(5));
        chk("st2_a11", 192'(bus.mac_vector_a_flat_44[191:176]), 192'(16'h40bb));
        tick();

        // reset mid-WAIT
        send_job(1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("mr_in_ready", 192'(bus.in_ready_44), 192'(1));
        chk("mr_busy", 192'(bus.busy_44), 192'(0));
        chk("mr_out_result", 192'(bus.out_result_44), 192'(0));
        chk("mr_flat_a", bus.mac_vector_a_flat_44, 192'(0));
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        bus.mac_done_44 = 1'b1;
        bus.mac_result_44 = 16'h1111;
        tick();
        bus.mac_done_44 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("mr_no_out", 192'(bus.out_valid_44), 192'(0));
            tick();
        end

        // fresh job after reset
        for (int i = 0; i < 12; i++) begin
            cur_a[i] = 16'h1234 + 16'(i);
            cur_b[i] = 16'habcd - 16'(i);
        end
        send_job(1'b0);
        s = tcyc;
        mac_pulse(7, 16'h3c00);
        wait_out(40, v);
        chk("fr_latency", 192'(v - s), 192'(8));
        chk("fr_result", 192'(bus.out_result_44), 192'(16'h3c00));
        chk("fr_a0", 192'(bus.mac_vector_a_flat_44[15:0]), 192'(16'h1234));
        chk("fr_b11", 192'(bus.mac_vector_b_flat_44[191:176]), 192'(16'habc2));
        tick();
        chk("fr_ready_back", 192'(bus.in_ready_44), 192'(1));
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/bf16_dot_feeder_44.md
Name: bf16_dot_feeder_44

Overview:
Initiator-side sequencer for the BF16 12-element dot-product unit BF16DotProduct_44.
- Accepts A/B element pairs one per handshake on a valid/ready stream and packs them into the 192-bit flat vectors the MAC consumes.
- Issues a one-cycle start, waits for done, captures the 16-bit result and returns it on an output valid/ready stream.
- Adds a done-timeout guard so a hung MAC cannot stall the datapath.

Parameters:
NUM_ELEM, 12, elements per dot product (flat width = NUM_ELEM*ELEM_W)
ELEM_W, 16, BF16 element width
TIMEOUT_CYCLES, 64, max cycles in WAIT before a timeout is declared
NAN_VALUE, 16'h7FC0, result substituted on timeout

Ports:
clk_44  in  1  single clock, rising edge
rst_n_44  in  1  asynchronous active-low reset
in_valid_44  in  1  element pair valid
in_ready_44  out  1  feeder can accept a pair
in_a_44  in  16  BF16 element of vector A
in_b_44  in  16  BF16 element of vector B
mac_start_44  out  1  one-cycle start pulse to MAC
mac_vector_a_flat_44  out  192  packed A; element i at [16i+15:16i]
mac_vector_b_flat_44  out  192  packed B; same packing
mac_done_44  in  1  MAC completion (level or pulse)
mac_result_44  in  16  MAC BF16 result
out_valid_44  out  1  result available
out_ready_44  in  1  downstream accepts result
out_result_44  out  16  captured BF16 result
busy_44  out  1  high in START/WAIT/OUTPUT
timeout_err_44  out  1  last job timed out

Behaviour:
Reset (async assert, sync release):
- state=LOAD, idx=0, flat vectors=0, mac_start=0, out_valid=0, out_result=0, timeout_err=0, done_q=0, timer=0.
- Reset mid-operation aborts the job; no start or output is emitted afterwards.

FSM states: LOAD, START, WAIT, OUTPUT.

LOAD:
- in_ready=1.
- On in_valid&in_ready, write in_a/in_b into slot idx, then idx++.
- Accepting slot NUM_ELEM-1 sets idx=0 and goes to START next cycle.
- Other slots keep their previous contents until overwritten.

START:
- in_ready=0, mac_start=1 for exactly one cycle.
- timer=0, timeout_err cleared. Next state is WAIT.

WAIT:
- in_ready=0, timer increments each cycle.
- done_q registers mac_done every cycle in every state. Completion = mac_done & ~done_q (rising edge), so a done level left over from the previous job is ignored.
- On completion: out_result<=mac_result, go to OUTPUT.
- If timer reaches TIMEOUT_CYCLES-1 without completion: out_result<=NAN_VALUE, timeout_err<=1, go to OUTPUT.
- Completion and timeout in the same cycle: completion wins.

OUTPUT:
- out_valid=1; out_result is held stable until out_valid&out_ready.
- On transfer, go to LOAD next cycle (out_valid=0, in_ready=1).
- in_ready stays 0 throughout OUTPUT, so there is no overlap of jobs.

Flat vectors are held stable from START until the first write of the next job.

Latency:
- Last pair accepted at cycle T → mac_start at T+1.
- Done edge at cycle D → out_valid at D+1.
- With out_ready=1, in_ready is back at D+2.
- Throughput: NUM_ELEM + MAC latency + 3 cycles per job.

busy = (state != LOAD).

Test Plan:
- Nominal: stream A=(3dcc,3e4c,3e80,be99,3ecc,3f00,3f0c,3f19,bf40,3f4c,3f60,3f66), B=(3e80,bf66,3e00,3f4c,3f60,bf40,3e99,3f19,3dcc,3e4c,becc,3f0c) with continuous valid; MAC model returns 3eb8 13 cycles after start → mac_vector_a_flat[15:0]=3dcc and [191:176]=3f66, one start pulse, out_result=3eb8, timeout_err=0.
- Input gaps: in_valid toggled randomly across the 12 pairs → packing identical to the nominal case, start issued exactly once, 1 cycle after the 12th accept.
- Output backpressure: out_ready low for 5 cycles after out_valid → out_result held at 3eb8, in_ready=0, no second start; transfer on the 6th cycle and in_ready=1 on the next cycle.
- Timeout: MAC never asserts done → out_valid 64 cycles after WAIT entry with out_result=7fc0, timeout_err=1; the next job's start clears timeout_err.
- Stale done: MAC holds done=1 from job 1 through job 2's start and drops it 2 cycles later, then pulses done with result 3f80 → job 2 returns 3f80, not the stale job-1 value.
- Reset mid-WAIT: assert rst_n_44=0 for 1 cycle while waiting → all outputs return to reset values immediately; a later done edge produces no out_valid; a fresh 12-pair load works normally.
